// File: rtl/flash_audio_reader_pkg.sv
// Shared definitions for the flash-side audio word reader: FSM encoding and
// default song bounds within the flash word-address space.
package flash_audio_reader_pkg;

  localparam int unsigned SONG_ADDR_W = 23;

  localparam logic [SONG_ADDR_W-1:0] SONG_START_ADDR = 23'h000000;
  localparam logic [SONG_ADDR_W-1:0] SONG_END_ADDR   = 23'h07FFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_VALID = 3'd2,
    DONE       = 3'd3,
    ADVANCE    = 3'd4
  } reader_state_e;

endpackage

// File: rtl/audio_addr_stepper.sv
// Combinational next-word address: a pending restart jumps to the song edge
// selected by direction, otherwise step one word with wrap-around.
module audio_addr_stepper #(
  parameter int ADDR_W = 23
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              direction_i,
  input  logic              restart_pend_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  always_comb begin
    // NOTE: every branch assigns next_addr_o, so no latch can be inferred.
    next_addr_o = addr_i;
    if (restart_pend_i) begin
      next_addr_o = direction_i ? start_addr_i : end_addr_i;
    end else if (direction_i) begin
      next_addr_o = (addr_i == end_addr_i) ? start_addr_i : addr_i + 1'b1;
    end else begin
      next_addr_o = (addr_i == start_addr_i) ? end_addr_i : addr_i - 1'b1;
    end
  end

endmodule

// File: rtl/flash_audio_reader.sv
// Fetches one 32-bit song word at a time over Avalon-MM, holds it for the
// sample unpacker, and steps the word address once the unpacker signals change.
module flash_audio_reader
  import flash_audio_reader_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = SONG_START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = SONG_END_ADDR
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              play,
  input  logic              direction,
  input  logic              restart,
  input  logic              change,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [31:0]       audio_data,
  output logic              finished
);

  reader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              restart_pend_q;
  logic              read_q;
  logic [31:0]       data_q;
  logic              finished_q;

  audio_addr_stepper #(.ADDR_W(ADDR_W)) u_stepper (
    .addr_i        (addr_q),
    .direction_i   (direction),
    .restart_pend_i(restart_pend_q),
    .start_addr_i  (START_ADDR),
    .end_addr_i    (END_ADDR),
    .next_addr_o   (addr_d)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= START_ADDR;
      restart_pend_q <= 1'b0;
      read_q         <= 1'b0;
      data_q         <= '0;
      finished_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on the values from before the clock edge.
      case (state_q)
        IDLE: begin
          if (restart) addr_q <= direction ? START_ADDR : END_ADDR;
          if (play) begin
            state_q <= ISSUE;
            read_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (restart) restart_pend_q <= 1'b1;
          if (!flash_waitrequest) begin
            read_q <= 1'b0;
            // A zero-latency slave may return data in the accept cycle.
            if (flash_readdatavalid) begin
              data_q     <= flash_readdata;
              finished_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= WAIT_VALID;
            end
          end
        end
        WAIT_VALID: begin
          if (restart) restart_pend_q <= 1'b1;
          if (flash_readdatavalid) begin
            data_q     <= flash_readdata;
            finished_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (restart) restart_pend_q <= 1'b1;
          if (change) begin
            finished_q <= 1'b0;
            state_q    <= ADVANCE;
          end
        end
        ADVANCE: begin
          // The pending jump is consumed here; a restart now waits for the next step.
          addr_q         <= addr_d;
          restart_pend_q <= restart;
          if (play) begin
            state_q <= ISSUE;
            read_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_read    = read_q;
  assign flash_address = addr_q;
  assign audio_data    = data_q;
  assign finished      = finished_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// Directed bench for flash_audio_reader with a small Avalon read-slave model.
module tb_flash_audio_reader;

  localparam logic [22:0] S_ADDR = 23'h000000;
  localparam logic [22:0] E_ADDR = 23'h07FFFF;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        direction = 1'b1;
  logic        restart = 1'b0;
  logic        change = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = 32'h0;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] audio_data;
  logic        finished;

  int checks = 0;
  int errors = 0;
  int rd_latency = 1;
  int accepts = 0;

  logic        pend = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_data = 32'h0;

  flash_audio_reader #(
    .ADDR_W    (23),
    .START_ADDR(S_ADDR),
    .END_ADDR  (E_ADDR)
  ) dut (
    .clk50              (clk50),
    .reset_n            (reset_n),
    .play               (play),
    .direction          (direction),
    .restart            (restart),
    .change             (change),
    .flash_read         (flash_read),
    .flash_address      (flash_address),
    .flash_waitrequest  (flash_waitrequest),
    .flash_readdata     (flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .audio_data         (audio_data),
    .finished           (finished)
  );

  always #10 clk50 = ~clk50;

  function automatic logic [31:0] model_word(input logic [22:0] a);
    return (a == 23'h0) ? 32'hAABBCCDD : ({9'h0, a} ^ 32'hC0DE0000);
  endfunction

  // Avalon slave: returns data rd_latency cycles after the accepting edge.
  always @(posedge clk50) begin
    if (!reset_n) begin
      flash_readdatavalid <= 1'b0;
      pend                <= 1'b0;
    end else begin
      flash_readdatavalid <= 1'b0;
      if (pend) begin
        if (lat_cnt <= 1) begin
          flash_readdatavalid <= 1'b1;
          flash_readdata      <= pend_data;
          pend                <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
      if (flash_read && !flash_waitrequest) begin
        accepts <= accepts + 1;
        if (rd_latency <= 1) begin
          flash_readdatavalid <= 1'b1;
          flash_readdata      <= model_word(flash_address);
        end else begin
          pend      <= 1'b1;
          lat_cnt   <= rd_latency - 1;
          pend_data <= model_word(flash_address);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    play = 1'b0;
    restart = 1'b0;
    change = 1'b0;
    flash_waitrequest = 1'b0;
    rd_latency = 1;
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
  endtask

  task automatic pulse_change();
    @(negedge clk50);
    change = 1'b1;
    @(negedge clk50);
    change = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk50);
    restart = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
  endtask

  // Waits (bounded) for finished, recording the address of the first read seen.
  task automatic wait_word(output logic [22:0] rd_addr, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    rd_addr = 'x;
    while (!finished && cycles < 60) begin
      @(negedge clk50);
      cycles++;
      if (flash_read && !seen) begin
        seen = 1'b1;
        rd_addr = flash_address;
      end
    end
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL word_timeout finished=%b after %0d cycles, required 1", finished, cycles);
    end
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    while (!flash_read && n < 20) begin
      @(negedge clk50);
      n++;
    end
    checks++;
    if (flash_read !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout flash_read=%b, required 1", flash_read);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk50);
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", flash_read); end
    checks++; if (flash_address !== S_ADDR) begin errors++; $display("FAIL rst_addr got %h exp %h", flash_address, S_ADDR); end
    checks++; if (audio_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", audio_data); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL rst_finished got %b exp 0", finished); end
    reset_n = 1'b1;
    @(negedge clk50);
  endtask

  task automatic test_first_word();
    logic [22:0] a;
    int n;
    do_reset();
    direction = 1'b1;
    play = 1'b1;
    wait_word(a, n);
    checks++; if (a !== 23'h0) begin errors++; $display("FAIL first_addr got %h exp 0", a); end
    checks++; if (audio_data !== 32'hAABBCCDD) begin errors++; $display("FAIL first_data got %h exp aabbccdd", audio_data); end
    repeat (3) @(negedge clk50);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL hold_finished got %b exp 1", finished); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL hold_read got %b exp 0", flash_read); end
    pulse_change();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL change_clears got %b exp 0", finished); end
    wait_word(a, n);
    checks++; if (a !== 23'h1) begin errors++; $display("FAIL second_addr got %h exp 1", a); end
    checks++; if (audio_data !== model_word(23'h1)) begin errors++; $display("FAIL second_data got %h exp %h", audio_data, model_word(23'h1)); end
    // Change cycle plus ADVANCE, ISSUE and WAIT_VALID: finished in the 4th cycle after change.
    checks++; if (n + 1 !== 4) begin errors++; $display("FAIL change_latency got %0d exp 4", n + 1); end
  endtask

  task automatic test_wraps();
    logic [22:0] a;
    int n;
    do_reset();
    direction = 1'b0;
    pulse_restart();
    checks++; if (flash_address !== E_ADDR) begin errors++; $display("FAIL idle_restart_addr got %h exp %h", flash_address, E_ADDR); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL idle_restart_read got %b exp 0", flash_read); end
    direction = 1'b1;
    play = 1'b1;
    wait_word(a, n);
    checks++; if (a !== E_ADDR) begin errors++; $display("FAIL end_addr got %h exp %h", a, E_ADDR); end
    checks++; if (audio_data !== model_word(E_ADDR)) begin errors++; $display("FAIL end_data got %h exp %h", audio_data, model_word(E_ADDR)); end
    pulse_change();
    wait_word(a, n);
    checks++; if (a !== S_ADDR) begin errors++; $display("FAIL fwd_wrap got %h exp %h", a, S_ADDR); end

    do_reset();
    direction = 1'b0;
    play = 1'b1;
    wait_word(a, n);
    checks++; if (a !== S_ADDR) begin errors++; $display("FAIL bwd_start got %h exp %h", a, S_ADDR); end
    pulse_change();
    wait_word(a, n);
    checks++; if (a !== E_ADDR) begin errors++; $display("FAIL bwd_wrap got %h exp %h", a, E_ADDR); end
    pulse_change();
    wait_word(a, n);
    checks++; if (a !== E_ADDR - 23'h1) begin errors++; $display("FAIL bwd_step got %h exp %h", a, E_ADDR - 23'h1); end
  endtask

  task automatic test_waitrequest();
    logic [22:0] a;
    logic [22:0] a0;
    int n;
    int acc0;
    do_reset();
    flash_waitrequest = 1'b1;
    direction = 1'b1;
    play = 1'b1;
    wait_read();
    a0 = flash_address;
    acc0 = accepts;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk50);
      checks++; if (flash_read !== 1'b1) begin errors++; $display("FAIL wait_read_%0d got %b exp 1", i, flash_read); end
      checks++; if (flash_address !== S_ADDR) begin errors++; $display("FAIL wait_addr_%0d got %h exp %h", i, flash_address, S_ADDR); end
    end
    flash_waitrequest = 1'b0;
    wait_word(a, n);
    checks++; if (accepts - acc0 !== 1) begin errors++; $display("FAIL accept_count got %0d exp 1", accepts - acc0); end
    checks++; if (a0 !== S_ADDR) begin errors++; $display("FAIL wait_first_addr got %h exp %h", a0, S_ADDR); end
    checks++; if (audio_data !== 32'hAABBCCDD) begin errors++; $display("FAIL wait_data got %h exp aabbccdd", audio_data); end
  endtask

  task automatic test_restart_pending();
    logic [22:0] a;
    int n;
    do_reset();
    direction = 1'b1;
    play = 1'b1;
    wait_word(a, n);
    for (int k = 1; k < 256; k++) begin
      pulse_change();
      wait_word(a, n);
    end
    checks++; if (a !== 23'h0000FF) begin errors++; $display("FAIL walk_addr got %h exp 0000ff", a); end
    rd_latency = 3;
    pulse_change();
    wait_read();
    checks++; if (flash_address !== 23'h000100) begin errors++; $display("FAIL pend_read_addr got %h exp 000100", flash_address); end
    @(negedge clk50);
    restart = 1'b1;
    direction = 1'b0;
    @(negedge clk50);
    restart = 1'b0;
    wait_word(a, n);
    checks++; if (audio_data !== model_word(23'h000100)) begin errors++; $display("FAIL pend_data got %h exp %h", audio_data, model_word(23'h000100)); end
    checks++; if (flash_address !== 23'h000100) begin errors++; $display("FAIL pend_hold_addr got %h exp 000100", flash_address); end
    rd_latency = 1;
    pulse_change();
    wait_word(a, n);
    checks++; if (a !== E_ADDR) begin errors++; $display("FAIL pend_jump got %h exp %h", a, E_ADDR); end
  endtask

  task automatic test_pause();
    logic [22:0] a;
    int n;
    play = 1'b0;
    repeat (3) @(negedge clk50);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL pause_finished got %b exp 1", finished); end
    pulse_change();
    repeat (3) @(negedge clk50);
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL pause_read got %b exp 0", flash_read); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL pause_cleared got %b exp 0", finished); end
    checks++; if (flash_address !== E_ADDR - 23'h1) begin errors++; $display("FAIL pause_addr got %h exp %h", flash_address, E_ADDR - 23'h1); end
    pulse_change();
    repeat (2) @(negedge clk50);
    checks++; if (flash_address !== E_ADDR - 23'h1) begin errors++; $display("FAIL idle_change_addr got %h exp %h", flash_address, E_ADDR - 23'h1); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL idle_change_read got %b exp 0", flash_read); end
    play = 1'b1;
    wait_word(a, n);
    checks++; if (a !== E_ADDR - 23'h1) begin errors++; $display("FAIL resume_addr got %h exp %h", a, E_ADDR - 23'h1); end
  endtask

  task automatic test_reset_midread();
    flash_waitrequest = 1'b1;
    pulse_change();
    wait_read();
    checks++; if (flash_address !== E_ADDR - 23'h2) begin errors++; $display("FAIL mid_addr got %h exp %h", flash_address, E_ADDR - 23'h2); end
    @(negedge clk50);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL async_read got %b exp 0", flash_read); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL async_finished got %b exp 0", finished); end
    checks++; if (audio_data !== 32'h0) begin errors++; $display("FAIL async_data got %h exp 0", audio_data); end
    play = 1'b0;
    flash_waitrequest = 1'b0;
    @(negedge clk50);
    reset_n = 1'b1;
    repeat (3) @(negedge clk50);
    checks++; if (flash_address !== S_ADDR) begin errors++; $display("FAIL post_rst_addr got %h exp %h", flash_address, S_ADDR); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL post_rst_read got %b exp 0", flash_read); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_word();
    test_wraps();
    test_waitrequest();
    test_restart_pending();
    test_pause();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
